// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that lets NUM_MASTERS requesters share one slave port.
// Each transaction runs IDLE -> ISSUE -> WAIT -> IDLE, with a one-cycle slave request in ISSUE.
// Optional feature macro: BUS_ARB_TIMEOUT_EN enables a WAIT watchdog of TIMEOUT_CYCLES cycles.
// When the watchdog fires, the owner gets an error completion and m_rdata is all ones.

module bus_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_valid,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS-1:0]            m_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_read,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              err,
    output logic                              s_valid,
    output logic                              s_write,
    output logic                              s_ready,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic                              s_read,
    input  logic [DATA_WIDTH-1:0]             s_rdata
);

    localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Reject parameter values the arbiter is not built for.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("bus_arbiter: NUM_MASTERS must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         owner_q, owner_d;
    logic [IdxW-1:0]         last_q, last_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [IdxW:0]           pick;      // {found, index}
    logic                    done;      // normal completion this cycle
    logic                    timeout;   // watchdog completion this cycle
    logic                    timeout_hit;

    // First requester at or after last+1, wrapping; MSB flags that one was found.
    function automatic logic [IdxW:0] rr_pick(input logic [NUM_MASTERS-1:0] valid,
                                              input logic [IdxW-1:0]        last);
        logic [IdxW:0] res;
        int unsigned   idx;
        res = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = (32'(last) + i) % NUM_MASTERS;
            if (!res[IdxW] && valid[IdxW'(idx)]) begin
                res = {1'b1, IdxW'(idx)};
            end
        end
        return res;
    endfunction

    assign pick = rr_pick(m_valid, last_q);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count cycles spent in WAIT; restarts from zero on every WAIT entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES));

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Forwarded accept is only meaningful while waiting on the slave.
    assign s_ready = (state_q == StWait) && m_ready[owner_q];

    // Next-state logic: arbitration, field latching and completion handling.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done    = 1'b0;
        timeout = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick[IdxW]) begin
                    owner_d          = pick[IdxW-1:0];
                    grant_d          = '0;
                    grant_d[owner_d] = 1'b1;
                    write_d          = m_write[owner_d];
                    addr_d           = m_addr[owner_d*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d          = m_wdata[owner_d*DATA_WIDTH +: DATA_WIDTH];
                    state_d          = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // A real slave completion beats a watchdog expiry in the same cycle.
                if (s_read && s_ready) begin
                    done    = 1'b1;
                    rdata_d = s_rdata;
                end else if (timeout_hit) begin
                    timeout = 1'b1;
                    rdata_d = '1;
                end
                if (done || timeout) begin
                    last_d  = owner_q;
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // Completion strobes are combinational so the earliest m_read lands in the first WAIT cycle.
    always_comb begin
        m_read  = '0;
        m_rdata = rdata_q;
        if (done || timeout) begin
            m_read  = grant_q;
            m_rdata = rdata_d;
        end
    end

    assign err     = timeout;
    assign grant   = grant_q;
    assign s_valid = (state_q == StIssue);
    assign s_write = write_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;

    // State and latched-field registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= IdxW'(NUM_MASTERS - 1);
            grant_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (4 masters, 32/16-bit buses).
// Covers both builds: with BUS_ARB_TIMEOUT_EN the watchdog is exercised at TIMEOUT_CYCLES = 8.

module tb_bus_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NM = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NM-1:0]    m_valid = '0;
    logic [NM-1:0]    m_write = '0;
    logic [NM-1:0]    m_ready = '0;
    logic [NM*AW-1:0] m_addr = '0;
    logic [NM*DW-1:0] m_wdata = '0;
    logic [NM-1:0]    m_read;
    logic [DW-1:0]    m_rdata;
    logic [NM-1:0]    grant;
    logic             err;
    logic             s_valid;
    logic             s_write;
    logic             s_ready;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic             s_read = 1'b0;
    logic [DW-1:0]    s_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    bus_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_valid (m_valid),
        .m_write (m_write),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_read  (m_read),
        .m_rdata (m_rdata),
        .grant   (grant),
        .err     (err),
        .s_valid (s_valid),
        .s_write (s_write),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_read  (s_read),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        s_read = 1'b0;
        m_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 16'h0010 + 16'(i * 16'h0010);
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // One full transaction for an owner expected to win at the next sample edge.
    task automatic run_txn(input int owner, input logic [DW-1:0] rd);
        logic [NM-1:0] oh;
        oh = 4'b0001 << owner;
        tick();                                   // ISSUE
        check("txn_grant", 64'(grant), 64'(oh));
        check("txn_s_valid", 64'(s_valid), 64'd1);
        check("txn_s_addr", 64'(s_addr), 64'(addr_of(owner)));
        check("txn_s_write", 64'(s_write), 64'(owner % 2 == 1));
        check("txn_s_wdata", 64'(s_wdata), 64'(wdata_of(owner)));
        tick();                                   // WAIT
        check("txn_wait_s_valid", 64'(s_valid), 64'd0);
        m_addr[owner*AW +: AW] = 16'hDEAD;        // must not disturb the latched address
        s_read  = 1'b1;
        s_rdata = rd;
        #1;
        check("txn_addr_held", 64'(s_addr), 64'(addr_of(owner)));
        check("txn_m_read", 64'(m_read), 64'(oh));
        check("txn_m_rdata", 64'(m_rdata), 64'(rd));
        tick();                                   // back in IDLE
        s_read = 1'b0;
        m_addr[owner*AW +: AW] = addr_of(owner);
        #1;
        check("txn_idle_grant", 64'(grant), 64'd0);
        check("txn_idle_m_read", 64'(m_read), 64'd0);
        check("txn_rdata_hold", 64'(m_rdata), 64'(rd));
    endtask

    initial begin
        for (int i = 0; i < NM; i++) begin
            m_addr[i*AW +: AW]  = addr_of(i);
            m_wdata[i*DW +: DW] = wdata_of(i);
        end
        m_write = 4'b1010;
        m_ready = 4'b1111;

        // Reset values
        #2;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_m_read", 64'(m_read), 64'd0);
        check("rst_m_rdata", 64'(m_rdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_s_valid", 64'(s_valid), 64'd0);
        check("rst_s_write", 64'(s_write), 64'd0);
        check("rst_s_addr", 64'(s_addr), 64'd0);
        check("rst_s_wdata", 64'(s_wdata), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        do_reset();

        // Single read from master 0 at 0x0010
        m_valid = 4'b0001;
        run_txn(0, 32'hA5A5_A5A5);
        m_valid = 4'b0000;

        // Stray s_read in IDLE is ignored
        s_read = 1'b1;
        #1;
        check("idle_s_read_ignored", 64'(m_read), 64'd0);
        tick();
        check("idle_stays_idle", 64'(s_valid), 64'd0);
        s_read = 1'b0;

        // All masters requesting continuously: strict rotation from master 0
        do_reset();
        m_valid = 4'b1111;
        run_txn(0, 32'h0000_1000);
        run_txn(1, 32'h0000_1001);
        run_txn(2, 32'h0000_1002);
        run_txn(3, 32'h0000_1003);
        run_txn(0, 32'h0000_1004);
        m_valid = 4'b0000;

        // Owner not ready: s_read ignored for 3 cycles, completes when m_ready rises
        do_reset();
        m_valid = 4'b0001;
        m_ready = 4'b0000;
        tick();
        m_valid = 4'b0000;
        tick();
        s_read  = 1'b1;
        s_rdata = 32'h1234_5678;
        #1;
        check("nready_s_ready", 64'(s_ready), 64'd0);
        check("nready_m_read0", 64'(m_read), 64'd0);
        tick();
        check("nready_m_read1", 64'(m_read), 64'd0);
        tick();
        check("nready_m_read2", 64'(m_read), 64'd0);
        tick();
        m_ready = 4'b0001;
        #1;
        check("ready_s_ready", 64'(s_ready), 64'd1);
        check("ready_m_read", 64'(m_read), 64'd1);
        check("ready_m_rdata", 64'(m_rdata), 64'h1234_5678);
        tick();
        s_read  = 1'b0;
        m_ready = 4'b1111;
        check("ready_idle_grant", 64'(grant), 64'd0);

        // Reset while waiting: immediate drop, no completion, master 0 wins afterwards
        m_valid = 4'b0100;
        tick();
        check("abort_grant", 64'(grant), 64'b0100);
        m_valid = 4'b0000;
        tick();
        s_read  = 1'b1;
        s_rdata = 32'h0BAD_0BAD;
        #1;
        reset = 1'b0;
        #1;
        check("abort_grant_clr", 64'(grant), 64'd0);
        check("abort_s_valid", 64'(s_valid), 64'd0);
        check("abort_m_read", 64'(m_read), 64'd0);
        check("abort_s_ready", 64'(s_ready), 64'd0);
        s_read = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        m_valid = 4'b0101;
        tick();
        check("post_rst_priority", 64'(grant), 64'b0001);
        m_valid = 4'b0000;
        tick();
        s_read  = 1'b1;
        s_rdata = 32'h0000_00AA;
        #1;
        check("post_rst_m_read", 64'(m_read), 64'b0001);
        tick();
        s_read = 1'b0;

        // Silent slave
        m_valid = 4'b0010;
        tick();
        m_valid = 4'b0000;
        tick();                                   // first WAIT cycle
`ifdef BUS_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            check("to_early_err", 64'(err), 64'd0);
            check("to_early_m_read", 64'(m_read), 64'd0);
            tick();
        end
        check("to_err", 64'(err), 64'd1);
        check("to_m_read", 64'(m_read), 64'b0010);
        check("to_m_rdata", 64'(m_rdata), 64'hFFFF_FFFF);
        tick();
        check("to_idle_grant", 64'(grant), 64'd0);
        check("to_idle_err", 64'(err), 64'd0);
        check("to_rdata_hold", 64'(m_rdata), 64'hFFFF_FFFF);

        // Slave completion in the expiry cycle wins over the watchdog
        m_valid = 4'b0010;
        tick();
        m_valid = 4'b0000;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        s_read  = 1'b1;
        s_rdata = 32'h5A5A_0000;
        #1;
        check("race_err", 64'(err), 64'd0);
        check("race_m_read", 64'(m_read), 64'b0010);
        check("race_m_rdata", 64'(m_rdata), 64'h5A5A_0000);
        tick();
        s_read = 1'b0;
`else
        for (int k = 0; k < 20; k++) begin
            check("wait_err", 64'(err), 64'd0);
            check("wait_m_read", 64'(m_read), 64'd0);
            check("wait_s_ready", 64'(s_ready), 64'd1);
            tick();
        end
        check("wait_grant_held", 64'(grant), 64'b0010);
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, the address bus width.
REQ-003 SHALL have parameter NUM_MASTERS, default 4, the requester count (range 2..8).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, the watchdog limit in WAIT (used only with BUS_ARB_TIMEOUT_EN).
REQ-005 SHALL have ports, one clock, reset asynchronous active-low:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset
- m_valid  input  NUM_MASTERS  per-master request
- m_write  input  NUM_MASTERS  per-master direction (1 = write)
- m_ready  input  NUM_MASTERS  per-master response-accept
- m_addr  input  NUM_MASTERS*ADDR_WIDTH  per-master address, master i at slice i
- m_wdata  input  NUM_MASTERS*DATA_WIDTH  per-master write data
- m_read  output  NUM_MASTERS  per-master one-cycle completion strobe
- m_rdata  output  DATA_WIDTH  shared read data, valid with m_read
- grant  output  NUM_MASTERS  one-hot owner, all-zero when idle
- err  output  1  one-cycle timeout-completion flag
- s_valid, s_write, s_ready  output  1 each  slave-side request, direction, forwarded accept
- s_addr  output  ADDR_WIDTH; s_wdata  output  DATA_WIDTH  slave-side request fields
- s_read  input  1  slave completion strobe; s_rdata  input  DATA_WIDTH  slave read data

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-007 IDLE: if any m_valid, SHALL select by round-robin starting at last_grant+1 (modulo NUM_MASTERS), latch that master's write/addr/wdata, set grant one-hot, go to ISSUE; otherwise stay, grant = 0.
REQ-008 ISSUE: SHALL drive s_valid = 1 for exactly one cycle with latched fields, then go to WAIT.
REQ-009 WAIT: SHALL drive s_ready = m_ready[owner] combinationally; s_write/s_addr/s_wdata held stable; s_valid = 0.
REQ-010 WAIT: on s_read && s_ready, SHALL pulse m_read[owner] for one cycle, drive m_rdata = s_rdata (read or write), set last_grant = owner, clear grant, go to IDLE.
REQ-011 Latency: request sampled in IDLE at cycle N, s_valid at N+1, earliest m_read at N+2; one IDLE cycle minimum between transactions.
REQ-012 Writes SHALL complete on s_read identically to reads (s_read acts as ack).
REQ-013 m_valid/m_addr/m_wdata changes after grant SHALL be ignored until return to IDLE.
REQ-014 A master keeping m_valid high after completion SHALL be re-arbitrated behind all other pending masters.
REQ-015 s_read outside WAIT, or in WAIT with s_ready = 0, SHALL be ignored.
REQ-016 m_read SHALL never be high for more than one master; m_rdata SHALL hold its last value when m_read = 0.

Reset
REQ-017 On reset low, SHALL asynchronously enter IDLE, dropping any in-flight transaction without a completion pulse.
REQ-018 Reset values: grant = 0, m_read = 0, m_rdata = 0, err = 0, s_valid = 0, s_write = 0, s_addr = 0, s_wdata = 0, s_ready = 0, last_grant = NUM_MASTERS-1 (master 0 wins first).

Configuration
REQ-019 With BUS_ARB_TIMEOUT_EN defined, SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES without completion, SHALL pulse m_read[owner] and err, drive m_rdata = all ones, and go to IDLE.
REQ-020 With BUS_ARB_TIMEOUT_EN, a valid s_read && s_ready in the timeout cycle SHALL win: normal completion, err = 0.
REQ-021 Without BUS_ARB_TIMEOUT_EN, SHALL contain no counter, tie err to 0, and wait in WAIT indefinitely.

Verification
REQ-022 Reset, then m_valid = 4'b0001 with addr 0x0010 -> grant = 0001, s_valid one cycle later with s_addr 0x0010; s_read with s_rdata 0xA5A5A5A5 -> m_read[0] pulse, m_rdata 0xA5A5A5A5.
REQ-023 m_valid = 4'b1111 held continuously -> grant order 0, 1, 2, 3, 0, each grant exactly once per four transactions.
REQ-024 Owner m_ready = 0 while s_read = 1 -> no completion; m_ready rises 3 cycles later -> completion that cycle.
REQ-025 Reset asserted in WAIT -> s_valid = 0, grant = 0 immediately, no m_read pulse; after release master 0 has priority.
REQ-026 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave silent -> m_read and err pulse 8 cycles after WAIT entry, m_rdata = 0xFFFFFFFF; without the macro -> FSM remains in WAIT, err = 0.
